// File: rtl/ack_nak_gen.sv
// Receive-side ACK/NAK generator: classifies each incoming TLP by sequence number and
// LCRC status, coalesces ACKs by count/latency, and issues NAKs for lost or corrupt TLPs.
module ack_nak_gen #(
  parameter int SEQ_W      = 12,
  parameter int ACK_LAT    = 64,
  parameter int ACK_THRESH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tlp_valid,
  input  logic [SEQ_W-1:0] tlp_seq,
  input  logic             lcrc_ok,
  output logic             tlp_accept,
  output logic             tlp_drop,
  output logic [1:0]       acknak,
  output logic [SEQ_W-1:0] acknak_seq,
  output logic             acknak_valid,
  input  logic             acknak_ready
);

  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] ACK_WAIT = 2'b01;
  localparam logic [1:0] SEND_ACK = 2'b10;
  localparam logic [1:0] SEND_NAK = 2'b11;

  localparam int TMR_W  = $clog2(ACK_LAT + 1);
  localparam int PEND_W = 8;
  localparam logic [SEQ_W-1:0]  HALF_RANGE = SEQ_W'(1 << (SEQ_W - 1));
  localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(ACK_LAT - 1);
  localparam logic [PEND_W-1:0] PEND_LIM   = PEND_W'(ACK_THRESH);

  logic [1:0]        state_q, state_d;
  logic [SEQ_W-1:0]  nrs_q, nrs_d;
  logic              nak_sched_q, nak_sched_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              accept_q, accept_d;
  logic              drop_q, drop_d;

  logic [SEQ_W-1:0]  diff;
  logic              nak_req;
  logic              dup;
  logic              ack_due;

  always_comb begin
    state_d     = state_q;
    nrs_d       = nrs_q;
    nak_sched_d = nak_sched_q;
    timer_d     = timer_q;
    pend_d      = pend_q;
    seq_d       = seq_q;
    accept_d    = 1'b0;
    drop_d      = 1'b0;
    nak_req     = 1'b0;
    dup         = 1'b0;
    diff        = nrs_q - tlp_seq;

    // Retire first so a same-edge TLP event sees the post-retire state.
    if (acknak_valid && acknak_ready) begin
      if (state_q == SEND_ACK) begin
        pend_d  = '0;
        timer_d = '0;
      end
      state_d = (pend_d != '0) ? ACK_WAIT : IDLE;
    end

    ack_due = (pend_d != '0) && (timer_d == TMR_LAST);
    if ((pend_d != '0) && (timer_d != TMR_LAST)) begin
      timer_d = timer_d + TMR_W'(1);
    end

    if (tlp_valid) begin
      if (lcrc_ok && (diff == '0)) begin
        accept_d    = 1'b1;
        nrs_d       = nrs_q + SEQ_W'(1);
        nak_sched_d = 1'b0;
        if (pend_d != '1) begin
          pend_d = pend_d + PEND_W'(1);
        end
      end else if (lcrc_ok && (diff <= HALF_RANGE)) begin
        drop_d = 1'b1;
        dup    = 1'b1;
      end else begin
        drop_d = 1'b1;
        if (!nak_sched_q) begin
          nak_req     = 1'b1;
          nak_sched_d = 1'b1;
        end
      end
    end

    if (pend_d >= PEND_LIM) begin
      ack_due = 1'b1;
    end

    // NAK wins over any ACK; a displaced ACK is dropped, not queued.
    case (state_d)
      IDLE, ACK_WAIT: begin
        if (nak_req) begin
          state_d = SEND_NAK;
          seq_d   = nrs_d - SEQ_W'(1);
        end else if (dup || ack_due) begin
          state_d = SEND_ACK;
          seq_d   = nrs_d - SEQ_W'(1);
        end else if (pend_d != '0) begin
          state_d = ACK_WAIT;
        end
      end
      SEND_ACK: begin
        if (nak_req) begin
          state_d = SEND_NAK;
          seq_d   = nrs_d - SEQ_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      nrs_q       <= '0;
      nak_sched_q <= 1'b0;
      timer_q     <= '0;
      pend_q      <= '0;
      seq_q       <= '0;
      accept_q    <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      nrs_q       <= nrs_d;
      nak_sched_q <= nak_sched_d;
      timer_q     <= timer_d;
      pend_q      <= pend_d;
      seq_q       <= seq_d;
      accept_q    <= accept_d;
      drop_q      <= drop_d;
    end
  end

  assign tlp_accept   = accept_q;
  assign tlp_drop     = drop_q;
  assign acknak_valid = state_q[1];
  assign acknak       = {state_q == SEND_NAK, state_q == SEND_ACK};
  assign acknak_seq   = acknak_valid ? seq_q : '0;

endmodule

// File: tb/tb_ack_nak_gen.sv
// Directed bench for ack_nak_gen: stimulus pushes hand-computed expectations into
// queues and an independent monitor compares them against DUT outputs.
module tb_ack_nak_gen;

  logic        clk;
  logic        reset;
  logic        tlp_valid;
  logic [11:0] tlp_seq;
  logic        lcrc_ok;
  logic        tlp_accept;
  logic        tlp_drop;
  logic [1:0]  acknak;
  logic [11:0] acknak_seq;
  logic        acknak_valid;
  logic        acknak_ready;

  int n_vec  = 0;
  int n_miss = 0;

  logic        exp_tlp[$];
  logic [13:0] exp_dll[$];
  logic        tlp_e;
  logic [13:0] dll_e;

  ack_nak_gen dut (
    .clk          (clk),
    .reset        (reset),
    .tlp_valid    (tlp_valid),
    .tlp_seq      (tlp_seq),
    .lcrc_ok      (lcrc_ok),
    .tlp_accept   (tlp_accept),
    .tlp_drop     (tlp_drop),
    .acknak       (acknak),
    .acknak_seq   (acknak_seq),
    .acknak_valid (acknak_valid),
    .acknak_ready (acknak_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  function automatic logic [13:0] ack(input int s);
    logic [11:0] s12;
    s12 = 12'(s);
    return {2'b01, s12};
  endfunction

  function automatic logic [13:0] nak(input int s);
    logic [11:0] s12;
    s12 = 12'(s);
    return {2'b10, s12};
  endfunction

  // Called just after a rising edge; presents one TLP for exactly one edge.
  task automatic tlp(input int s, input logic ok, input logic exp_acc);
    exp_tlp.push_back(exp_acc);
    tlp_valid = 1'b1;
    tlp_seq   = 12'(s);
    lcrc_ok   = ok;
    @(posedge clk);
    #1;
    tlp_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tlp_valid = 1'b0;
    #2;
    check("reset_outputs", {16'd0, tlp_accept, tlp_drop, acknak, acknak_valid, acknak_seq}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (tlp_accept || tlp_drop) begin
        if (exp_tlp.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL tlp_unexpected: accept=%0b drop=%0b, required no pulse", tlp_accept, tlp_drop);
        end else begin
          tlp_e = exp_tlp.pop_front();
          check("tlp_class", {30'd0, tlp_accept, tlp_drop}, tlp_e ? 32'd2 : 32'd1);
        end
      end
      if (acknak_valid && acknak_ready) begin
        $display("dllp %s seq=%0d", (acknak == 2'b01) ? "ACK" : "NAK", acknak_seq);
        if (exp_dll.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL dllp_unexpected: type=%0b seq=%0d, required none", acknak, acknak_seq);
        end else begin
          dll_e = exp_dll.pop_front();
          check("dllp", {18'd0, acknak, acknak_seq}, {18'd0, dll_e});
        end
      end
    end
  end

  initial begin
    int found;
    reset        = 1'b1;
    tlp_valid    = 1'b0;
    tlp_seq      = '0;
    lcrc_ok      = 1'b0;
    acknak_ready = 1'b1;

    // 1: threshold ACK lands with the 4th accept
    do_reset();
    tlp(0, 1'b1, 1'b1);
    tlp(1, 1'b1, 1'b1);
    tlp(2, 1'b1, 1'b1);
    exp_dll.push_back(ack(3));
    tlp(3, 1'b1, 1'b1);
    check("thresh_ack_with_accept", {28'd0, tlp_accept, acknak_valid, acknak}, 32'hD);
    idle(3);

    // 2: single accept, latency-forced ACK after 64 cycles
    do_reset();
    exp_dll.push_back(ack(0));
    tlp(0, 1'b1, 1'b1);
    found = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (acknak_valid) begin
        found = k;
        break;
      end
    end
    check("ack_latency", found, 64);
    idle(3);

    // 3: bad CRC -> one NAK, out-of-order dropped silently, resend clears nak_sched
    do_reset();
    tlp(0, 1'b1, 1'b1);
    exp_dll.push_back(nak(0));
    tlp(1, 1'b0, 1'b0);
    tlp(2, 1'b1, 1'b0);
    tlp(1, 1'b1, 1'b1);
    exp_dll.push_back(nak(1));
    tlp(5, 1'b0, 1'b0);
    exp_dll.push_back(ack(1));
    idle(80);

    // 4: duplicate after nrs=5 -> immediate ACK 4, nrs unchanged
    do_reset();
    tlp(0, 1'b1, 1'b1);
    tlp(1, 1'b1, 1'b1);
    tlp(2, 1'b1, 1'b1);
    exp_dll.push_back(ack(3));
    tlp(3, 1'b1, 1'b1);
    tlp(4, 1'b1, 1'b1);
    exp_dll.push_back(ack(4));
    tlp(3, 1'b1, 1'b0);
    check("dup_ack_immediate", {30'd0, acknak}, 32'd1);
    tlp(5, 1'b1, 1'b1);
    exp_dll.push_back(ack(5));
    idle(70);

    // 5: sequence wrap 4095 -> 0, then duplicate across the wrap
    do_reset();
    for (int i = 0; i < 4095; i++) begin
      if (i % 4 == 3) exp_dll.push_back(ack(i));
      tlp(i, 1'b1, 1'b1);
    end
    exp_dll.push_back(ack(4095));
    tlp(4095, 1'b1, 1'b1);
    tlp(0, 1'b1, 1'b1);
    exp_dll.push_back(ack(0));
    tlp(4095, 1'b1, 1'b0);
    idle(3);

    // 6: held NAK stays stable, accept during hold, then async reset mid-hold
    do_reset();
    acknak_ready = 1'b0;
    tlp(0, 1'b1, 1'b1);
    tlp(7, 1'b0, 1'b0);
    tlp(1, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      check("hold_nak", {17'd0, acknak_valid, acknak, acknak_seq}, {17'd0, 1'b1, 2'b10, 12'd0});
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_outs", {16'd0, tlp_accept, tlp_drop, acknak, acknak_valid, acknak_seq}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    acknak_ready = 1'b1;
    idle(3);
    check("post_reset_idle", {29'd0, acknak_valid, acknak}, 32'd0);

    check("tlp_queue_empty", exp_tlp.size(), 0);
    check("dllp_queue_empty", exp_dll.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
